gmm_in_ram_loader: RTL and testbench

GMM_IN_RAM_LOADER -- requirements
Module: gmm_in_ram_loader

---
 rtl/gmm_pkg.sv | 22 ++
 rtl/gmm_lane_packer.sv | 79 +++++++
 rtl/gmm_in_ram_loader.sv | 152 +++++++++++++++
 tb/tb_gmm_in_ram_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmm_pkg.sv
// Shared definitions for the GMM parameter RAM loader.
//   LANES       : 32-bit beats packed into one RAM word
//   HALF_WORDS  : RAM words per ping-pong half
//   RAM_*       : RAM address / data / byte-enable widths for the defaults
//   gmm_state_e : loader FSM states
package gmm_pkg;

    localparam int LANES      = 8;
    localparam int HALF_WORDS = 32;
    localparam int BEAT_W     = 32;
    localparam int RAM_AW     = $clog2(HALF_WORDS) + 1;
    localparam int RAM_DW     = LANES * BEAT_W;
    localparam int RAM_BEW    = RAM_DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } gmm_state_e;

endpackage

// File: rtl/gmm_lane_packer.sv
// Lane accumulator: collects 32-bit beats into a LANES-wide RAM word.
//   clk, reset  : clock, async active-high reset
//   beat_valid  : store beat_data in the next free lane
//   beat_data   : beat payload
//   flush       : emit a partially filled word (no-op when nothing is pending)
//   word_last   : current beat completes a word (combinational)
//   pending     : at least one lane holds data
//   wr_valid    : registered write strobe, one cycle per emitted word
//   wr_data     : emitted word, beat k at bits [32k+31:32k], unfilled lanes zero
//   wr_be       : byte enables of the filled lanes
module gmm_lane_packer #(
    parameter int LANES = gmm_pkg::LANES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  beat_valid,
    input  logic [31:0]           beat_data,
    input  logic                  flush,
    output logic                  word_last,
    output logic                  pending,
    output logic                  wr_valid,
    output logic [32*LANES-1:0]   wr_data,
    output logic [4*LANES-1:0]    wr_be
);
    import gmm_pkg::*;

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0][31:0] acc;
    logic [LANES-1:0][31:0] word_full;
    logic [LW-1:0]          lane_cnt;
    logic [4*LANES-1:0]     be_part;

    assign word_last = beat_valid && (lane_cnt == LW'(LANES - 1));
    assign pending   = (lane_cnt != '0);

    // Completed word: the accumulated lanes plus the beat arriving now in the top lane.
    always_comb begin
        word_full          = acc;
        word_full[LANES-1] = beat_data;
    end

    always_comb begin
        be_part = '0;
        for (int k = 0; k < LANES; k++)
            if (k < int'(lane_cnt)) be_part[4*k +: 4] = 4'hF;
    end

    // The accumulator clears in the cycle a word is emitted, so the next beat
    // lands in lane 0 without a bubble and unfilled lanes of a partial word read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            lane_cnt <= '0;
            wr_valid <= 1'b0;
            wr_data  <= '0;
            wr_be    <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (word_last) begin
                wr_data  <= word_full;
                wr_be    <= '1;
                wr_valid <= 1'b1;
                acc      <= '0;
                lane_cnt <= '0;
            end else if (beat_valid) begin
                acc[lane_cnt] <= beat_data;
                lane_cnt      <= lane_cnt + 1'b1;
            end else if (flush && pending) begin
                wr_data  <= acc;
                wr_be    <= be_part;
                wr_valid <= 1'b1;
                acc      <= '0;
                lane_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gmm_in_ram_loader.sv
// Loads an Avalon-ST stream of GMM parameter beats into a ping-pong RAM.
//   clk, reset                  : clock, async active-high reset
//   snk_data/valid/sop/eop      : Avalon-ST sink beat and qualifiers
//   snk_ready                   : sink backpressure (ready latency 0)
//   ram_address                 : {half, word_idx}
//   ram_chipselect/ram_write    : one-cycle write strobe per RAM word
//   ram_writedata/byteenable    : packed word and per-byte enables
//   ram_clken                   : constant 1
//   buf_done/buf_half/buf_words : one-cycle completion report per filled half
//   rel_valid/rel_half          : consumer hands a half back
//   err_overflow/err_framing    : sticky, cleared by the next accepted sop
module gmm_in_ram_loader #(
    parameter int LANES      = gmm_pkg::LANES,
    parameter int HALF_WORDS = gmm_pkg::HALF_WORDS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   snk_data,
    input  logic                          snk_valid,
    input  logic                          snk_sop,
    input  logic                          snk_eop,
    output logic                          snk_ready,
    output logic [$clog2(HALF_WORDS):0]   ram_address,
    output logic                          ram_chipselect,
    output logic                          ram_write,
    output logic [32*LANES-1:0]           ram_writedata,
    output logic [4*LANES-1:0]            ram_byteenable,
    output logic                          ram_clken,
    output logic                          buf_done,
    output logic                          buf_half,
    output logic [$clog2(HALF_WORDS):0]   buf_words,
    input  logic                          rel_valid,
    input  logic                          rel_half,
    output logic                          err_overflow,
    output logic                          err_framing
);
    import gmm_pkg::*;

    localparam int WI     = $clog2(HALF_WORDS);
    localparam int WIDX_W = WI + 1;

    gmm_state_e         state, state_n;
    logic               half;
    logic [1:0]         busy, busy_n;
    logic [WIDX_W-1:0]  word_idx;
    logic               full;
    logic               ready_c;
    logic               take;
    logic               flush;
    logic               word_last;
    logic               pending;
    logic               wr_valid;

    assign full = (word_idx == WIDX_W'(HALF_WORDS));

    always_comb begin
        state_n = state;
        ready_c = 1'b0;
        take    = 1'b0;
        flush   = 1'b0;
        unique case (state)
            IDLE: begin
                ready_c = !busy[half];
                // Only a sop opens a packet; stray beats are swallowed.
                if (snk_valid && ready_c && snk_sop) begin
                    take    = 1'b1;
                    state_n = snk_eop ? FLUSH : FILL;
                end
            end
            FILL: begin
                ready_c = 1'b1;
                if (snk_valid) begin
                    // Beats beyond a full half are accepted but dropped.
                    take = !full;
                    if (snk_eop) state_n = FLUSH;
                end
            end
            FLUSH: begin
                flush   = 1'b1;
                state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Ready is forced low during reset so every output reads 0 except clken.
    assign snk_ready = ready_c && !reset;

    // Apply the release first so a DONE on the same half wins.
    always_comb begin
        busy_n = busy;
        if (rel_valid) busy_n[rel_half] = 1'b0;
        if (state == DONE) busy_n[half] = 1'b1;
    end

    gmm_lane_packer #(.LANES(LANES)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .beat_valid (take && snk_ready),
        .beat_data  (snk_data),
        .flush      (flush),
        .word_last  (word_last),
        .pending    (pending),
        .wr_valid   (wr_valid),
        .wr_data    (ram_writedata),
        .wr_be      (ram_byteenable)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            half         <= 1'b0;
            busy         <= 2'b00;
            word_idx     <= '0;
            ram_address  <= '0;
            err_overflow <= 1'b0;
            err_framing  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= busy_n;

            if (state == IDLE && take) begin
                err_overflow <= 1'b0;
                err_framing  <= 1'b0;
            end
            if (state == FILL && snk_valid) begin
                if (full)    err_overflow <= 1'b1;
                if (snk_sop) err_framing  <= 1'b1;
            end

            // Address is captured alongside the packer's data so both present together.
            if (word_last || (flush && pending)) begin
                ram_address <= {half, word_idx[WI-1:0]};
                word_idx    <= word_idx + 1'b1;
            end

            if (state == DONE) begin
                half     <= ~half;
                word_idx <= '0;
            end
        end
    end

    assign ram_chipselect = wr_valid;
    assign ram_write      = wr_valid;
    assign ram_clken      = 1'b1;
    assign buf_done       = (state == DONE);
    assign buf_half       = buf_done && half;
    assign buf_words      = buf_done ? word_idx : '0;

endmodule

// File: tb/tb_gmm_in_ram_loader.sv
// Self-checking bench for gmm_in_ram_loader: random packets scored against a
// packet-level model of the expected RAM image, done report and flags.
module tb_gmm_in_ram_loader;

    localparam int L   = 8;
    localparam int HW  = 32;
    localparam int CAP = L * HW;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  snk_data;
    logic         snk_valid, snk_sop, snk_eop, snk_ready;
    logic [5:0]   ram_address;
    logic         ram_chipselect, ram_write, ram_clken;
    logic [255:0] ram_writedata;
    logic [31:0]  ram_byteenable;
    logic         buf_done, buf_half;
    logic [5:0]   buf_words;
    logic         rel_valid, rel_half;
    logic         err_overflow, err_framing;

    gmm_in_ram_loader dut (
        .clk(clk), .reset(reset),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
        .snk_ready(snk_ready),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
        .buf_done(buf_done), .buf_half(buf_half), .buf_words(buf_words),
        .rel_valid(rel_valid), .rel_half(rel_half),
        .err_overflow(err_overflow), .err_framing(err_framing)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int eop_cyc = 0;
    int done_cnt = 0;
    bit gaps = 1'b0;

    // Reference state: which half is next and which halves the consumer still owns.
    bit       mhalf = 1'b0;
    bit [1:0] mbusy = 2'b00;

    logic [31:0]  pkt[$];
    int           wq[$];
    logic [255:0] dq[$];
    logic [31:0]  bq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_chipselect && ram_write) begin
            wq.push_back(int'(ram_address));
            dq.push_back(ram_writedata);
            bq.push_back(ram_byteenable);
        end
        if (buf_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic make_pkt(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back($urandom());
    endtask

    task automatic send(input int sop_extra, input int stop);
        int w;
        for (int i = 0; i < stop; i++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                snk_valid = 1'b0;
                @(negedge clk);
            end
            snk_valid = 1'b1;
            snk_data  = pkt[i];
            snk_sop   = (i == 0) || (i == sop_extra);
            snk_eop   = (i == pkt.size() - 1);
            #1;
            w = 0;
            while (!snk_ready && w < 300) begin
                @(negedge clk);
                #1;
                w++;
            end
            chk("beat_ready", snk_ready, 1);
            eop_cyc = cyc;
            @(posedge clk);
        end
        @(negedge clk);
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
    endtask

    // Send pkt as one packet, optionally releasing a half in the DONE cycle,
    // then score writes, the done report and the flags against the model.
    task automatic run_pkt(input int sop_extra, input bit rel_en, input bit rel_h);
        int n      = pkt.size();
        int stored = (n < CAP) ? n : CAP;
        int nw     = (stored + L - 1) / L;
        int base   = int'(mhalf) * HW;
        int w;
        int idx;
        logic [255:0] ed;
        logic [31:0]  eb;
        wq.delete(); dq.delete(); bq.delete();
        send(sop_extra, n);
        #1;
        w = 0;
        while (!buf_done && w < 40) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("done_seen", buf_done, 1);
        chk("done_latency", cyc - eop_cyc, 2);
        chk("buf_half", buf_half, mhalf);
        chk("buf_words", buf_words, nw);
        if (rel_en) begin
            rel_valid = 1'b1;
            rel_half  = rel_h;
        end
        @(negedge clk);
        rel_valid = 1'b0;
        mbusy[mhalf] = 1'b1;
        if (rel_en && rel_h != mhalf) mbusy[rel_h] = 1'b0;
        mhalf = ~mhalf;
        repeat (2) @(negedge clk);
        #1;
        chk("wr_count", wq.size(), nw);
        for (int k = 0; k < wq.size() && k < nw; k++) begin
            ed = '0;
            eb = '0;
            for (int j = 0; j < L; j++) begin
                idx = k * L + j;
                if (idx < stored) begin
                    ed[32*j +: 32] = pkt[idx];
                    eb[4*j +: 4]   = 4'hF;
                end
            end
            chk("wr_addr", wq[k], base + k);
            chk("wr_data", dq[k], ed);
            chk("wr_be", bq[k], eb);
        end
        chk("err_overflow", err_overflow, n > CAP);
        chk("err_framing", err_framing, sop_extra > 0);
        chk("idle_ready", snk_ready, !mbusy[mhalf]);
    endtask

    task automatic release_half(input bit h);
        @(negedge clk);
        rel_valid = 1'b1;
        rel_half  = h;
        @(negedge clk);
        rel_valid = 1'b0;
        mbusy[h] = 1'b0;
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        snk_data = '0; snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
        rel_valid = 1'b0; rel_half = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", snk_ready, 0);
        chk("rst_clken", ram_clken, 1);
        chk("rst_write", {ram_chipselect, ram_write}, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_data", ram_writedata, 0);
        chk("rst_be", ram_byteenable, 0);
        chk("rst_done", {buf_done, buf_half, buf_words}, 0);
        chk("rst_err", {err_overflow, err_framing}, 0);
        reset = 1'b0;

        // Full half with an incrementing pattern.
        pkt.delete();
        for (int i = 0; i < 256; i++) pkt.push_back(32'(i));
        run_pkt(-1, 1'b0, 1'b0);
        if (dq.size() > 0)
            chk("word0", dq[0], 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
        release_half(1'b0);

        // Short packet ending in a partial word.
        gaps = 1'b1;
        make_pkt(10);
        run_pkt(-1, 1'b0, 1'b0);
        release_half(~mhalf);

        // Overflow: beats past the half are dropped.
        make_pkt(300);
        run_pkt(-1, 1'b0, 1'b0);
        release_half(~mhalf);

        // Stray sop mid-packet is stored as data and flagged.
        make_pkt(20);
        run_pkt(5, 1'b0, 1'b0);
        release_half(~mhalf);

        // Next sop clears the sticky flags; single-beat sop+eop packet.
        make_pkt(1);
        run_pkt(-1, 1'b0, 1'b0);
        release_half(~mhalf);
        make_pkt(19);
        run_pkt(-1, 1'b0, 1'b0);
        release_half(~mhalf);

        // Fill both halves, then a third packet must wait for a release.
        make_pkt(16);
        run_pkt(-1, 1'b0, 1'b0);
        make_pkt(13);
        run_pkt(-1, 1'b0, 1'b0);
        gaps = 1'b0;
        make_pkt(11);
        fork
            run_pkt(-1, 1'b0, 1'b0);
            begin
                repeat (6) @(negedge clk);
                #2;
                chk("blocked_ready", snk_ready, 0);
                chk("blocked_nowrite", wq.size(), 0);
                @(negedge clk);
                rel_valid = 1'b1;
                rel_half  = mhalf;
                mbusy[mhalf] = 1'b0;
                @(negedge clk);
                rel_valid = 1'b0;
            end
        join
        release_half(1'b0);
        release_half(1'b1);

        // Release colliding with DONE on the same half, then on the other half.
        gaps = 1'b1;
        make_pkt(9);
        run_pkt(-1, 1'b1, mhalf);
        make_pkt(8);
        run_pkt(-1, 1'b0, 1'b0);
        release_half(mhalf);
        make_pkt(12);
        run_pkt(-1, 1'b1, ~mhalf);
        make_pkt(7);
        run_pkt(-1, 1'b0, 1'b0);
        release_half(1'b0);
        release_half(1'b1);

        // Reset in the middle of a packet.
        gaps = 1'b0;
        make_pkt(30);
        send(-1, 12);
        reset = 1'b1;
        wq.delete(); dq.delete(); bq.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_ready", snk_ready, 0);
        chk("midrst_clken", ram_clken, 1);
        reset = 1'b0;
        mhalf = 1'b0;
        mbusy = 2'b00;
        repeat (10) @(negedge clk);
        #1;
        chk("midrst_nowrite", wq.size(), 0);
        chk("midrst_nodone", done_cnt, d0);
        make_pkt(17);
        run_pkt(-1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
